multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences one shared ALU, the branch-target shift/adder path, the register file, the IR and a single unified memory port over 3–5 states per instruction.
- Emits the 2-bit ALUop consumed by the existing ALU-control decoder.
- Adds a ready handshake to memory so slow memory stalls the sequence without corrupting state.

Parameters:
- OPC_W, 6, opcode field width (instruction bits 31:26).
- STATE_W, 4, width of the state register and of the debug state output.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR opcode field; valid from DECODE onward.
- zero  in  1  ALU Zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_en  out  1  PC load enable, = pc_write | (branch & zero).
- pc_write  out  1  unconditional PC write.
- branch  out  1  conditional PC write (beq).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load enable.
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A register.
- alu_src_b  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_dbg  out  4  current state encoding.

Behaviour:
- Moore FSM. Outputs are decoded combinationally from the state register, qualified by mem_ready where stated.
- While rst = 1: state forced to FETCH asynchronously and every output forced to 0.
- Reset released mid-instruction: restarts at FETCH; no partial write-back.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPEWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11. Encodings 12–15 go to FETCH.
- Outputs not listed for a state are 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - PC and IR update exactly once per instruction.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 100011 (lw) and 101011 (sw) -> MEMADR; 000000 -> EXEC; 000100 -> BEQ; 000010 -> JUMP; 001000 -> ADDIEX.
  - Any other opcode -> FETCH with illegal_op=1 for this cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next: RTYPEWB.
- RTYPEWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1, pc_source=01. Next: FETCH.
- JUMP: pc_write=1, pc_source=10. Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- Latency with mem_ready tied high, in cycles:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each cycle mem_ready is low in FETCH/MEMRD/MEMWR adds 1.
- Invariants:
  - mem_read and mem_write never both 1.
  - reg_write never in the same cycle as mem_write.
  - opcode is ignored in every state except DECODE and MEMADR.

Decomposition:
- Shared package mips_pkg holds:
  - state encodings;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - ALUOP_ADD/SUB/FUNCT;
  - ALUSRCB_* and PCSRC_* codes.
- One sub-module, mc_next_state: pure combinational next-state logic taking state, opcode and mem_ready.
- The top module holds the state register and the output decode.

Test Plan:
- rst=1 asserted mid-MEMRD -> state_dbg=0 and all outputs 0 immediately, with no clock edge needed. After release: FETCH with mem_read=1 and alu_src_b=01.
- lw (opcode 100011), mem_ready=1 throughout -> state_dbg sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. Total 5 cycles.
- sw with mem_ready low for 3 cycles in MEMWR -> stays in state 5 for 4 cycles with mem_write=1 and iord=1, then FETCH. reg_write never asserted.
- beq: zero=1 in BEQ -> pc_en=1, pc_source=01. Repeat with zero=0 -> pc_en=0. Both return to FETCH after 3 cycles.
- R-type then addi back-to-back -> alu_op=10 in EXEC and reg_dst=1 in RTYPEWB; then alu_src_b=10 and alu_op=00 in ADDIEX and reg_dst=0 in ADDIWB.
- Opcode 111111 in DECODE -> illegal_op pulses 1 for exactly one cycle; next state FETCH. No reg_write or mem_write at any point.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state encodings,
// opcode constants, datapath select codes and the packed control word.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQ     = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    // True for every opcode the control FSM knows how to sequence.
    function automatic logic opcode_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ok = 1'b1;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_next_state.sv
// Pure combinational next-state logic for the multi-cycle control FSM.
module mc_next_state
    import mips_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [3:0]       state,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    output logic [3:0]       next_state
);

    // Next-state selection; unused encodings fall back to FETCH.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    next_state = S_DECODE;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXEC;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDIEX;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_SW) begin
                    next_state = S_MEMWR;
                end else begin
                    next_state = S_MEMRD;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end else begin
                    next_state = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    next_state = S_FETCH;
                end else begin
                    next_state = S_MEMWR;
                end
            end
            S_EXEC:    next_state = S_RTYPEWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            S_MEMWB, S_RTYPEWB, S_BEQ, S_JUMP, S_ADDIWB: next_state = S_FETCH;
            default:   next_state = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: state register plus
// Moore output decode, with memory steps stalled by mem_ready.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               pc_write,
    output logic               branch,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    logic [3:0] state_r;
    logic [3:0] next_state_s;
    ctrl_t      ctrl_s;
    ctrl_t      ctrl_out_s;

    mc_next_state #(.OPC_W(OPC_W)) u_next_state (
        .state      (state_r),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .next_state (next_state_s)
    );

    // State register; reset drops straight back to FETCH, abandoning any write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Output decode from the current state; PC/IR only load when the fetch completes.
    always_comb begin
        ctrl_s = {$bits(ctrl_t){1'b0}};
        case (state_r)
            S_FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_FOUR;
                ctrl_s.alu_op    = ALUOP_ADD;
                ctrl_s.pc_source = PCSRC_ALU;
                ctrl_s.ir_write  = mem_ready;
                ctrl_s.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl_s.alu_src_b  = ALUSRCB_IMM_SH2;
                ctrl_s.alu_op     = ALUOP_ADD;
                ctrl_s.illegal_op = ~opcode_legal(opcode);
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_IMM;
                ctrl_s.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_B;
                ctrl_s.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = ALUSRCB_B;
                ctrl_s.alu_op    = ALUOP_SUB;
                ctrl_s.branch    = 1'b1;
                ctrl_s.pc_source = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_s.pc_write  = 1'b1;
                ctrl_s.pc_source = PCSRC_JUMP;
            end
            S_ADDIWB: begin
                ctrl_s.reg_write = 1'b1;
            end
            default: begin
                ctrl_s = {$bits(ctrl_t){1'b0}};
            end
        endcase
    end

    // Hold every control line low for as long as reset is asserted.
    always_comb begin
        if (rst) begin
            ctrl_out_s = {$bits(ctrl_t){1'b0}};
        end else begin
            ctrl_out_s = ctrl_s;
        end
    end

    assign pc_write   = ctrl_out_s.pc_write;
    assign branch     = ctrl_out_s.branch;
    assign iord       = ctrl_out_s.iord;
    assign mem_read   = ctrl_out_s.mem_read;
    assign mem_write  = ctrl_out_s.mem_write;
    assign ir_write   = ctrl_out_s.ir_write;
    assign mem_to_reg = ctrl_out_s.mem_to_reg;
    assign reg_dst    = ctrl_out_s.reg_dst;
    assign reg_write  = ctrl_out_s.reg_write;
    assign alu_src_a  = ctrl_out_s.alu_src_a;
    assign alu_src_b  = ctrl_out_s.alu_src_b;
    assign alu_op     = ctrl_out_s.alu_op;
    assign pc_source  = ctrl_out_s.pc_source;
    assign illegal_op = ctrl_out_s.illegal_op;
    assign pc_en      = ctrl_out_s.pc_write | (ctrl_out_s.branch & zero);
    assign state_dbg  = STATE_W'(state_r);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed table, randomized
// instruction stream against an instruction-level model, and a reset corner case.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, pc_write, branch, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state_dbg;

    int tests = 0;
    int fails = 0;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_write(pc_write), .branch(branch), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en, pc_write, branch, iord, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       illegal_op;
        logic [3:0] state_dbg;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic       mr;
        logic       z;
        int         st;
    } step_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AI = 6'b001000;

    outs_t act;
    assign act = {pc_en, pc_write, branch, iord, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, illegal_op, state_dbg};

    function automatic bit legal(input logic [5:0] op);
        return op inside {LW, SW, RT, BQ, JJ, AI};
    endfunction

    function automatic step_t mk(input logic [5:0] op, input logic mr, input logic z, input int st);
        step_t s;
        s.op = op; s.mr = mr; s.z = z; s.st = st;
        return s;
    endfunction

    // Expected outputs straight from the per-state control table.
    function automatic outs_t exp_outs(input int st, input logic mr, input logic z, input logic [5:0] op);
        outs_t o;
        o = '0;
        o.state_dbg = 4'(st);
        case (st)
            0:  begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
            1:  begin o.alu_src_b = 2'b11; o.illegal_op = !legal(op); end
            2:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            3:  begin o.mem_read = 1'b1; o.iord = 1'b1; end
            4:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
            5:  begin o.mem_write = 1'b1; o.iord = 1'b1; end
            6:  begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
            7:  begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
            8:  begin o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.branch = 1'b1; o.pc_source = 2'b01; end
            9:  begin o.pc_write = 1'b1; o.pc_source = 2'b10; end
            10: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            11: begin o.reg_write = 1'b1; end
            default: o = '0;
        endcase
        o.pc_en = o.pc_write | (o.branch & z);
        return o;
    endfunction

    task automatic check(input string name, input outs_t got, input outs_t want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic apply(input string name, input step_t s);
        @(negedge clk);
        opcode = s.op; mem_ready = s.mr; zero = s.z;
        #2;
        check(name, act, exp_outs(s.st, s.mr, s.z, s.op));
    endtask

    // Instruction-level model: expected state per cycle for one instruction.
    task automatic build(input logic [5:0] op, input int sf, input int sm, output step_t q[$]);
        q.delete();
        for (int i = 0; i < sf; i++) q.push_back(mk(6'($urandom), 1'b0, 1'($urandom), 0));
        q.push_back(mk(6'($urandom), 1'b1, 1'($urandom), 0));
        q.push_back(mk(op, 1'($urandom), 1'($urandom), 1));
        if (op == LW) begin
            q.push_back(mk(op, 1'($urandom), 1'($urandom), 2));
            for (int i = 0; i < sm; i++) q.push_back(mk(op, 1'b0, 1'($urandom), 3));
            q.push_back(mk(op, 1'b1, 1'($urandom), 3));
            q.push_back(mk(op, 1'($urandom), 1'($urandom), 4));
        end else if (op == SW) begin
            q.push_back(mk(op, 1'($urandom), 1'($urandom), 2));
            for (int i = 0; i < sm; i++) q.push_back(mk(op, 1'b0, 1'($urandom), 5));
            q.push_back(mk(op, 1'b1, 1'($urandom), 5));
        end else if (op == RT) begin
            q.push_back(mk(op, 1'($urandom), 1'($urandom), 6));
            q.push_back(mk(op, 1'($urandom), 1'($urandom), 7));
        end else if (op == BQ) begin
            q.push_back(mk(op, 1'($urandom), 1'($urandom), 8));
        end else if (op == JJ) begin
            q.push_back(mk(op, 1'($urandom), 1'($urandom), 9));
        end else if (op == AI) begin
            q.push_back(mk(op, 1'($urandom), 1'($urandom), 10));
            q.push_back(mk(op, 1'($urandom), 1'($urandom), 11));
        end
    endtask

    initial begin
        step_t tbl[$];
        step_t q[$];
        logic [5:0] op;
        int k;
        outs_t zero_outs;
        zero_outs = '0;

        // Directed table: lw, sw with 3 stall cycles, beq taken/not taken, R-type then addi, illegal.
        tbl.push_back(mk(6'h3F, 1'b1, 1'b0, 0)); tbl.push_back(mk(LW, 1'b1, 1'b0, 1));
        tbl.push_back(mk(LW, 1'b1, 1'b0, 2));    tbl.push_back(mk(LW, 1'b1, 1'b0, 3));
        tbl.push_back(mk(LW, 1'b1, 1'b0, 4));
        tbl.push_back(mk(6'h00, 1'b1, 1'b0, 0)); tbl.push_back(mk(SW, 1'b1, 1'b0, 1));
        tbl.push_back(mk(SW, 1'b1, 1'b0, 2));    tbl.push_back(mk(SW, 1'b0, 1'b0, 5));
        tbl.push_back(mk(SW, 1'b0, 1'b0, 5));    tbl.push_back(mk(SW, 1'b0, 1'b0, 5));
        tbl.push_back(mk(SW, 1'b1, 1'b0, 5));
        tbl.push_back(mk(6'h00, 1'b1, 1'b0, 0)); tbl.push_back(mk(BQ, 1'b1, 1'b0, 1));
        tbl.push_back(mk(BQ, 1'b1, 1'b1, 8));
        tbl.push_back(mk(6'h00, 1'b1, 1'b1, 0)); tbl.push_back(mk(BQ, 1'b1, 1'b1, 1));
        tbl.push_back(mk(BQ, 1'b1, 1'b0, 8));
        tbl.push_back(mk(6'h00, 1'b1, 1'b0, 0)); tbl.push_back(mk(RT, 1'b1, 1'b0, 1));
        tbl.push_back(mk(RT, 1'b1, 1'b0, 6));    tbl.push_back(mk(RT, 1'b1, 1'b0, 7));
        tbl.push_back(mk(6'h00, 1'b1, 1'b0, 0)); tbl.push_back(mk(AI, 1'b1, 1'b0, 1));
        tbl.push_back(mk(AI, 1'b1, 1'b0, 10));   tbl.push_back(mk(AI, 1'b1, 1'b0, 11));
        tbl.push_back(mk(6'h00, 1'b1, 1'b0, 0)); tbl.push_back(mk(6'h3F, 1'b1, 1'b0, 1));
        tbl.push_back(mk(6'h3F, 1'b0, 1'b0, 0));

        #3;
        check("reset_state", act, zero_outs);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply($sformatf("table[%0d]", i), tbl[i]);

        // Randomized instruction stream, including stalls and illegal opcodes.
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 6);
            case (k)
                0: op = LW;
                1: op = SW;
                2: op = RT;
                3: op = BQ;
                4: op = JJ;
                5: op = AI;
                default: begin
                    op = 6'($urandom);
                    while (legal(op)) op = 6'($urandom);
                end
            endcase
            build(op, $urandom_range(0, 2), $urandom_range(0, 3), q);
            for (int i = 0; i < q.size(); i++) apply($sformatf("rand[%0d].%0d op=%b", n, i, op), q[i]);
        end

        // Reset asserted while stalled in MEMRD, between clock edges.
        apply("rst_seq_fetch", mk(LW, 1'b1, 1'b0, 0));
        apply("rst_seq_decode", mk(LW, 1'b1, 1'b0, 1));
        apply("rst_seq_memadr", mk(LW, 1'b1, 1'b0, 2));
        apply("rst_seq_memrd", mk(LW, 1'b0, 1'b0, 3));
        rst = 1'b1;
        #1;
        check("rst_mid_memrd", act, zero_outs);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #2;
        check("after_rst_fetch", act, exp_outs(0, 1'b0, 1'b0, LW));
        apply("after_rst_fetch_stall", mk(LW, 1'b0, 1'b0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
